// File: rtl/key_encoder_tx_if.sv
// Byte link from the key encoder to uart_tx.
// master drives data/strobe, slave reports busy.
interface key_encoder_tx_if;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_send,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_send,
        output tx_busy
    );
endinterface

// File: rtl/key_encoder_tx.sv
// Six debounced buttons -> queued ASCII key bytes -> uart_tx.
// Optional macro AUTO_REPEAT_EN adds held-key auto-repeat.
module key_encoder_tx #(
    parameter int FIFO_DEPTH    = 4,
    parameter int GAP_CYCLES    = 16,
    parameter int BUSY_TIMEOUT  = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        up_btn,
    input  logic                        down_btn,
    input  logic                        left_btn,
    input  logic                        right_btn,
    input  logic                        enter_btn,
    input  logic                        space_btn,
    key_encoder_tx_if.master            tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        idle
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (GAP_CYCLES > BUSY_TIMEOUT)
                        ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    generate
        if (FIFO_DEPTH < 2
            || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
            || GAP_CYCLES < 1 || BUSY_TIMEOUT < 1
            || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
        begin : g_bad_param
            $error("key_encoder_tx: bad parameter");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP
    } state_t;

    // bit 0 is the highest priority key
    logic [5:0] btn;
    logic [5:0] prev;
    logic [5:0] ev_q;
    logic [5:0] req;

    assign btn = {space_btn, enter_btn, right_btn,
                  left_btn, down_btn, up_btn};

    function automatic logic [7:0] encode(input logic [5:0] oh);
        logic [7:0] b;
        b = 8'h00;
        priority case (1'b1)
            oh[0]:   b = 8'h77;
            oh[1]:   b = 8'h73;
            oh[2]:   b = 8'h61;
            oh[3]:   b = 8'h64;
            oh[4]:   b = 8'h0D;
            oh[5]:   b = 8'h20;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= '0;
            ev_q <= '0;
        end else begin
            prev <= btn;
            ev_q <= btn & ~prev;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                        ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [5:0]    hold;
    logic [5:0]    hold_q;
    logic [5:0]    rep_sel;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rlim;
    logic          rfirst;
    logic          rep_fire;

    // lowest set bit = highest-priority held key
    assign hold = prev & (~prev + 6'd1);
    assign rlim = rfirst ? RW'(REPEAT_DELAY - 1)
                         : RW'(REPEAT_PERIOD - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q   <= '0;
            rep_sel  <= '0;
            rcnt     <= '0;
            rfirst   <= 1'b1;
            rep_fire <= 1'b0;
        end else begin
            hold_q   <= hold;
            rep_fire <= 1'b0;
            if (hold != hold_q || (ev_q & hold) != '0) begin
                rcnt   <= '0;
                rfirst <= 1'b1;
            end else if (|hold) begin
                if (rcnt == rlim) begin
                    rep_fire <= 1'b1;
                    rep_sel  <= hold;
                    rcnt     <= '0;
                    rfirst   <= 1'b0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end

    assign req = ev_q | (rep_fire ? rep_sel : 6'd0);
`else
    assign req = ev_q;
`endif

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        wr_ok;
    logic        multi;
    logic [7:0]  wdata;

    assign push  = |req;
    assign wdata = encode(req);
    assign multi = |(req & (req - 6'd1));
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW])
                && (wp[AW-1:0] == rp[AW-1:0]);
    // a same-cycle pop frees the slot we write
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wp[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (multi || (push && !wr_ok))
                overflow <= 1'b1;
        end
    end

    assign fifo_level = wp - rp;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [7:0]    data_q;
    logic [7:0]    data_n;
    logic          send_q;
    logic          send_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            data_q <= '0;
            send_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            send_q <= send_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = data_q;
        send_n  = 1'b0;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty && !tx.tx_busy) begin
                    data_n  = mem[rp[AW-1:0]];
                    send_n  = 1'b1;
                    pop     = 1'b1;
                    cnt_n   = '0;
                    state_n = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx.tx_busy) begin
                    state_n = S_WAIT_LO;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!tx.tx_busy) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1))
                    state_n = S_IDLE;
                else
                    cnt_n = cnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign tx.tx_data = data_q;
    assign tx.tx_send = send_q;
    assign idle       = empty && (state == S_IDLE);

endmodule

// File: tb/tb_key_encoder_tx.sv
// Bench for key_encoder_tx: directed steps plus random presses
// checked against a byte-queue model and a uart_tx busy model.
module tb_key_encoder_tx;

    localparam int FD       = 4;
    localparam int GAP      = 16;
    localparam int BT       = 4;
    localparam int RD       = 20;
    localparam int RP       = 10;
    localparam int BUSY_LEN = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       up_btn = 1'b0;
    logic       down_btn = 1'b0;
    logic       left_btn = 1'b0;
    logic       right_btn = 1'b0;
    logic       enter_btn = 1'b0;
    logic       space_btn = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       idle;

    key_encoder_tx_if bus ();

    always #5 clk = ~clk;

    key_encoder_tx #(
        .FIFO_DEPTH   (FD),
        .GAP_CYCLES   (GAP),
        .BUSY_TIMEOUT (BT),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up_btn    (up_btn),
        .down_btn  (down_btn),
        .left_btn  (left_btn),
        .right_btn (right_btn),
        .enter_btn (enter_btn),
        .space_btn (space_btn),
        .tx        (bus),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .idle      (idle)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         model_en = 1'b1;
    bit         forced = 1'b0;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    logic [7:0] codes [6] = '{8'h77, 8'h73, 8'h61,
                              8'h64, 8'h0D, 8'h20};

    task automatic chk(input string tag, input int obs,
                       input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] code_of(input logic [5:0] m);
        for (int i = 0; i < 6; i++)
            if (m[i]) return codes[i];
        return 8'h00;
    endfunction

    task automatic set_btn(input logic [5:0] m);
        up_btn    = m[0];
        down_btn  = m[1];
        left_btn  = m[2];
        right_btn = m[3];
        enter_btn = m[4];
        space_btn = m[5];
    endtask

    task automatic press(input logic [5:0] m, input int hi,
                         input int lo);
        set_btn(m);
        repeat (hi) @(negedge clk);
        set_btn(6'd0);
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_idle(input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (idle) break;
        end
        chk("idle_reached", int'(k < lim), 1);
    endtask

    task automatic apply_reset();
        set_btn(6'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic compare_got(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_byte"}, got[i], exp_q[i]);
    endtask

    // uart_tx stand-in: goes busy for BUSY_LEN cycles per send
    initial begin
        int   busy_left;
        int   last_rel;
        int   last_send;
        int   rel;
        logic mb;
        logic mb_q;
        logic ps;
        busy_left = 0;
        last_rel  = -1000;
        last_send = -1000;
        mb_q = 1'b0;
        ps   = 1'b0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                busy_left = 0;
                last_rel  = -1000;
                last_send = -1000;
                mb_q = 1'b0;
                ps   = 1'b0;
                bus.tx_busy = forced;
            end else begin
                if (bus.tx_send) begin
                    chk("send_while_busy", bus.tx_busy, 0);
                    chk("send_one_cycle", ps, 0);
                    rel = (last_rel > last_send + BT - 1)
                        ? last_rel : last_send + BT - 1;
                    chk("send_gap", int'(cyc - rel >= GAP + 2), 1);
                    got.push_back(bus.tx_data);
                    last_send = cyc;
                    if (model_en) busy_left = BUSY_LEN;
                end
                ps = bus.tx_send;
                mb = (busy_left > 0);
                bus.tx_busy = forced | mb;
                if (busy_left > 0) busy_left--;
                if (mb_q && !mb) last_rel = cyc;
                mb_q = mb;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          ovf_exp;
        logic [5:0]  m;
        int          n;

        repeat (3) @(negedge clk);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_tx_send", bus.tx_send, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_idle", idle, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single up press: latency, byte, idle recovery
        got.delete();
        up_btn = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) up_btn = 1'b0;
            if (bus.tx_send) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 3);
        chk("up_byte", bus.tx_data, 8'h77);
        repeat (BUSY_LEN + GAP) @(negedge clk);
        chk("idle_before_gap_end", idle, 0);
        @(negedge clk);
        chk("idle_after_gap", idle, 1);
        chk("tx_data_held", bus.tx_data, 8'h77);
        chk("t1_count", got.size(), 1);

        // up and enter together
        got.delete();
        chk("ovf_before_multi", overflow, 0);
        press(6'b010001, 1, 1);
        repeat (3) @(negedge clk);
        wait_idle(200);
        exp_q = '{8'h77};
        compare_got("multi");
        chk("ovf_multi", overflow, 1);

        // random presses vs byte-queue model
        apply_reset();
        got.delete();
        exp_q.delete();
        ovf_exp = 1'b0;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 3) == 0)
                    m = 6'($urandom_range(1, 63));
                else
                    m = 6'd1 << $urandom_range(0, 5);
                exp_q.push_back(code_of(m));
                if ($countones(m) > 1) ovf_exp = 1'b1;
                press(m, $urandom_range(1, 3), $urandom_range(1, 2));
            end
            repeat (3) @(negedge clk);
            wait_idle(300);
        end
        compare_got("rand");
        chk("rand_overflow", overflow, int'(ovf_exp));

        // fill the queue while the link is held busy
        apply_reset();
        got.delete();
        forced = 1'b1;
        repeat (2) @(negedge clk);
        press(6'b001000, 1, 1);
        press(6'b000100, 1, 1);
        press(6'b100000, 1, 1);
        press(6'b000010, 1, 1);
        repeat (3) @(negedge clk);
        chk("full_level", fifo_level, 4);
        chk("full_no_ovf", overflow, 0);
        press(6'b000001, 1, 1);
        repeat (3) @(negedge clk);
        chk("full_level_drop", fifo_level, 4);
        chk("full_ovf", overflow, 1);
        forced = 1'b0;
        repeat (3) @(negedge clk);
        wait_idle(400);
        exp_q = '{8'h64, 8'h61, 8'h20, 8'h73};
        compare_got("full");

        // busy never rises: timeout path
        model_en = 1'b0;
        got.delete();
        space_btn = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) space_btn = 1'b0;
            if (bus.tx_send) begin
                lat = k;
                break;
            end
        end
        chk("to_latency", lat, 3);
        chk("to_byte", bus.tx_data, 8'h20);
        repeat (BT + GAP - 1) @(negedge clk);
        chk("to_idle_early", idle, 0);
        @(negedge clk);
        chk("to_idle", idle, 1);
        press(6'b100000, 1, 1);
        repeat (3) @(negedge clk);
        wait_idle(100);
        exp_q = '{8'h20, 8'h20};
        compare_got("to");
        model_en = 1'b1;

        // reset while in WAIT_LO with two bytes queued
        got.delete();
        set_btn(6'b000001);
        @(negedge clk);
        set_btn(6'b000011);
        @(negedge clk);
        set_btn(6'b000111);
        @(negedge clk);
        set_btn(6'b000000);
        chk("mid_send", bus.tx_send, 1);
        @(negedge clk);
        chk("mid_level", fifo_level, 2);
        chk("mid_data", bus.tx_data, 8'h77);
        reset = 1'b0;
        #1;
        chk("mid_rst_data", bus.tx_data, 0);
        chk("mid_rst_send", bus.tx_send, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_idle", idle, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_no_send", got.size(), 1);
        chk("mid_idle", idle, 1);

`ifdef AUTO_REPEAT_EN
        apply_reset();
        got.delete();
        press(6'b000010, 45, 1);
        repeat (3) @(negedge clk);
        wait_idle(400);
        n = 0;
        foreach (got[i]) if (got[i] == 8'h73) n++;
        chk("rep_count", int'(n >= 3 && n <= 4), 1);
        chk("rep_only_s", n, got.size());
        chk("rep_ovf", overflow, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
